// File: rtl/ysq_pkg.sv
// Shared definitions for the y-squared result UART transmitter.
package ysq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int BYTES_PER_WORD       = 2;
    localparam int BITS_PER_BYTE        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

endpackage

// File: rtl/ysq_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and raises tick once per period.
module ysq_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // tick marks the second-to-last count so the FSM can update one cycle ahead of the line.
    localparam logic [CNT_W-1:0]   CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count and registered tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_PRE);
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ysq_result_tx.sv
// Serializes a 16-bit result word as two back-to-back UART 8N1 frames, low byte first.
module ysq_result_tx
    import ysq_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              byte_q,  byte_d;
    logic [2:0]        bit_q,   bit_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              ready_q, ready_d;
    logic              done_q,  done_d;
    logic              clear_s;
    logic              tick_s;

    ysq_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // FSM runs one cycle ahead of tx; tx_q replays the current state's bit, so the
    // final stop bit's last cycle coincides with IDLE and a new word can start gap-free.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = START;
                    shift_d = in_data;
                    byte_d  = 1'b0;
                    bit_d   = 3'd0;
                    clear_s = 1'b1;
                    tx_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (byte_q == 1'(BYTES_PER_WORD - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            byte_q  <= 1'b0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ysq_result_tx.sv
// Directed bench for ysq_result_tx: line-level decode of frames at three bit periods.
module tb_ysq_result_tx;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0][15:0] d_v;
    logic [2:0]      v_v;
    logic [2:0]      rdy_v;
    logic [2:0]      tx_v;
    logic [2:0]      busy_v;
    logic [2:0]      done_v;
    int              n_tests = 0;
    int              n_fail  = 0;

    always #5 clk = ~clk;

    ysq_result_tx #(.CLKS_PER_BIT(4), .DATA_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d_v[0]), .in_valid(v_v[0]),
        .in_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    ysq_result_tx #(.CLKS_PER_BIT(2), .DATA_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(d_v[1]), .in_valid(v_v[1]),
        .in_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    ysq_result_tx #(.CLKS_PER_BIT(87), .DATA_W(16)) u_dut87 (
        .clk(clk), .rst_n(rst_n), .in_data(d_v[2]), .in_valid(v_v[2]),
        .in_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit slot b (0..19) of a word's two frames.
    function automatic logic fbit(input logic [15:0] w, input int b);
        if (b == 0 || b == 10) return 1'b0;
        if (b == 9 || b == 19) return 1'b1;
        if (b < 10) return w[b-1];
        return w[b-3];
    endfunction

    task automatic xfer(input int sel, input int n, input logic [15:0] w0, input logic [15:0] w1,
                        input int nwords, input bit ignore_test, input bit armed);
        logic        tx_r [0:2047];
        logic        dn_r [0:2047];
        logic        rd_r [0:2047];
        logic        bz_r [0:2047];
        logic [15:0] words [2];
        logic [15:0] dec;
        logic [1:0]  stops;
        int          len, guard, herr, ferr, done_at, base, mid;
        bit          bnd;
        words[0] = w0;
        words[1] = w1;
        len = 20 * n * nwords;
        if (!armed) begin
            @(negedge clk);
            d_v[sel] = w0;
            v_v[sel] = 1'b1;
        end
        guard = 0;
        while (!rdy_v[sel] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 32'(guard < 100), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            tx_r[k] = tx_v[sel];
            dn_r[k] = done_v[sel];
            rd_r[k] = rdy_v[sel];
            bz_r[k] = busy_v[sel];
            if (k == 1) begin
                if (nwords == 2)      d_v[sel] = w1;
                else if (ignore_test) d_v[sel] = 16'h5555;
                else                  v_v[sel] = 1'b0;
            end
            if (nwords == 2 && k == 20 * n + 1) v_v[sel] = 1'b0;
            if (ignore_test && k == 20 * n - 10) v_v[sel] = 1'b0;
        end
        herr = 0;
        for (int w = 0; w < nwords; w++) begin
            dec   = 16'h0000;
            stops = 2'b00;
            for (int b = 0; b < 20; b++) begin
                base = w * 20 * n + b * n;
                for (int s = 1; s <= n; s++) begin
                    if (tx_r[base + s] !== fbit(words[w], b)) herr++;
                end
                mid = base + n / 2 + 1;
                if (b >= 1 && b <= 8)   dec[b-1] = tx_r[mid];
                if (b >= 11 && b <= 18) dec[b-3] = tx_r[mid];
                if (b == 9)  stops[0] = tx_r[mid];
                if (b == 19) stops[1] = tx_r[mid];
            end
            chk($sformatf("decode_w%0d_n%0d", w, n), 32'(dec), 32'(words[w]));
            chk($sformatf("stop_bits_w%0d_n%0d", w, n), 32'(stops), 32'd3);
        end
        chk($sformatf("bit_hold_n%0d", n), 32'(herr), 32'd0);
        ferr    = 0;
        done_at = 0;
        for (int k = 1; k <= len; k++) begin
            bnd = (k % (20 * n) == 0);
            if (dn_r[k] !== bnd)  ferr++;
            if (rd_r[k] !== bnd)  ferr++;
            if (bz_r[k] !== !bnd) ferr++;
            if (dn_r[k] === 1'b1 && done_at == 0) done_at = k;
        end
        chk($sformatf("flags_n%0d", n), 32'(ferr), 32'd0);
        chk($sformatf("done_at_n%0d", n), 32'(done_at), 32'(20 * n));
        chk($sformatf("idle_after_n%0d", n), 32'(tx_r[len + 1]), 32'd1);
        chk($sformatf("no_extra_done_n%0d", n), 32'(dn_r[len + 1]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        d_v   = '0;
        v_v   = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx_v[0]),   32'd1);
        chk("rst_busy",  32'(busy_v[0]), 32'd0);
        chk("rst_ready", 32'(rdy_v[0]),  32'd1);
        chk("rst_done",  32'(done_v[0]), 32'd0);
        rst_n = 1'b1;

        // Abort 0xABCD partway through its first data byte.
        @(negedge clk);
        d_v[0] = 16'hABCD;
        v_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx",    32'(tx_v[0]),   32'd1);
        chk("abort_busy",  32'(busy_v[0]), 32'd0);
        chk("abort_ready", 32'(rdy_v[0]),  32'd1);
        chk("abort_done",  32'(done_v[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_done", 32'(done_v[0]), 32'd0);
        end

        // Release with a word already offered: accepted on the first rising edge.
        @(negedge clk);
        rst_n  = 1'b1;
        d_v[0] = 16'h1234;
        v_v[0] = 1'b1;
        xfer(0, 4, 16'h1234, 16'h0000, 1, 1'b0, 1'b1);

        xfer(0, 4, 16'h00FF, 16'hFF00, 2, 1'b0, 1'b0);
        xfer(0, 4, 16'h0001, 16'h0000, 1, 1'b1, 1'b0);
        xfer(0, 4, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
        xfer(0, 4, 16'hFFFF, 16'h0000, 1, 1'b0, 1'b0);
        xfer(1, 2, 16'hA55A, 16'h0000, 1, 1'b0, 1'b0);
        xfer(2, 87, 16'hA55A, 16'h0000, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
